imem_responder: RTL and testbench

- Instruction-memory responder: the memory end of the CPU fetch interface. The CPU drives PC; this block returns the instruction word.
- Contains a word-addressed instruction store and a byte-serial program loader.
- Replaces the bench-driven instruction supply, so the CPU can run self-contained programs in simulation and on FPGA.

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_byte_packer.sv | 29 ++
 rtl/imem_responder.sv | 168 ++++++++++++++++
 tb/tb_imem_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam int DEPTH_WORDS_DEF = 256;

  // addi x0, x0, 0: returned whenever there is no valid instruction to give.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE
  } imem_ld_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles a little-endian byte stream into 32-bit words.
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic [7:0]  data_byte,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0] byte_cnt;

  // The counter wraps 3 -> 0 on the fourth byte, so it is already zero when the word is committed.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt <= 2'd0;
    end else if (accept) begin
      word[{byte_cnt, 3'b000} +: 8] <= data_byte;
      byte_cnt                      <= byte_cnt + 2'd1;
    end
  end

  // High when the byte being accepted this cycle completes a word.
  always_comb begin
    word_done = accept && (byte_cnt == 2'd3);
  end

endmodule

// File: rtl/imem_responder.sv
// Memory end of the CPU fetch interface: word store plus byte-serial program loader.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | serving fetches; waiting for ld_start
// LOAD  | accepting bytes into the packer (ld_ready while not full)
// WRITE | committing the assembled word to mem[ptr]
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PC_i,
  input  logic             fetch_en,
  output logic [31:0]      ins,
  output logic             ins_valid,
  output logic             fetch_err,
  input  logic             ld_start,
  input  logic             ld_end,
  input  logic             ld_valid,
  input  logic [7:0]       ld_byte,
  output logic             ld_ready,
  output logic             ld_busy,
  output logic [IDX_W:0]   ld_words
);

  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W + 1)'(DEPTH_WORDS);
  localparam logic [31:0]    SPAN      = 32'(4 * DEPTH_WORDS);

  imem_ld_state_t state, state_nxt;

  logic [31:0]    mem [DEPTH_WORDS];
  logic [IDX_W:0] ptr;
  logic           end_pend, end_pend_nxt;
  logic           cnt_clear, cnt_inc, mem_we;
  logic           pk_accept, pk_clear, pk_done;
  logic [31:0]    pk_word;
  logic [31:0]    f_off;
  logic [IDX_W-1:0] f_idx;

  assign ld_ready  = (state == LOAD) && (ptr < DEPTH_CNT);
  assign ld_busy   = (state != IDLE);
  // A restart in LOAD drops any byte offered in the same cycle.
  assign pk_accept = ld_valid && ld_ready && !ld_start;

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .accept    (pk_accept),
    .data_byte (ld_byte),
    .clear     (pk_clear),
    .word      (pk_word),
    .word_done (pk_done)
  );

  // Loader state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Loader next-state and control strobes.
  always_comb begin
    state_nxt    = state;
    end_pend_nxt = end_pend;
    cnt_clear    = 1'b0;
    cnt_inc      = 1'b0;
    mem_we       = 1'b0;
    pk_clear     = 1'b0;
    case (state)
      IDLE: begin
        if (ld_start) begin
          state_nxt    = LOAD;
          cnt_clear    = 1'b1;
          pk_clear     = 1'b1;
          end_pend_nxt = 1'b0;
        end
      end
      LOAD: begin
        if (ld_start) begin
          cnt_clear    = 1'b1;
          pk_clear     = 1'b1;
          end_pend_nxt = 1'b0;
        end else if (pk_done) begin
          state_nxt    = WRITE;
          end_pend_nxt = ld_end;
        end else if (ld_end) begin
          state_nxt = IDLE;
          pk_clear  = 1'b1;
        end
      end
      WRITE: begin
        mem_we       = 1'b1;
        end_pend_nxt = 1'b0;
        if (ld_start) begin
          state_nxt = LOAD;
          cnt_clear = 1'b1;
          pk_clear  = 1'b1;
        end else begin
          cnt_inc   = 1'b1;
          state_nxt = (end_pend || ld_end) ? IDLE : LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word pointer, committed-word count and pending end.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      ld_words <= '0;
      end_pend <= 1'b0;
    end else begin
      end_pend <= end_pend_nxt;
      if (cnt_clear) begin
        ptr      <= '0;
        ld_words <= '0;
      end else if (cnt_inc) begin
        ptr      <= ptr + 1'b1;
        ld_words <= ld_words + 1'b1;
      end
    end
  end

  // Array write; a reset landing on a WRITE cycle suppresses the commit.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[ptr[IDX_W-1:0]] <= pk_word;
  end

  assign f_off = PC_i - BASE_ADDR;
  assign f_idx = f_off[IDX_W+1:2];

  // Registered fetch response; only served while the loader is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ins       <= NOP_INSN;
      ins_valid <= 1'b0;
      fetch_err <= 1'b0;
    end else if (fetch_en) begin
      if (state != IDLE) begin
        ins       <= NOP_INSN;
        ins_valid <= 1'b0;
        fetch_err <= 1'b0;
      end else begin
        ins_valid <= 1'b1;
        if ((f_off[1:0] != 2'b00) || (f_off >= SPAN)) begin
          ins       <= NOP_INSN;
          fetch_err <= 1'b1;
        end else if ({1'b0, f_idx} >= ld_words) begin
          ins       <= NOP_INSN;
          fetch_err <= 1'b0;
        end else begin
          ins       <= mem[f_idx];
          fetch_err <= 1'b0;
        end
      end
    end else begin
      ins_valid <= 1'b0;
      fetch_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: fetch paths, loader FSM corners, fill and reset.
module tb_imem_responder;

  localparam int DEPTH = 256;
  localparam int IW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   PC_i = '0;
  logic          fetch_en = 1'b0;
  logic [31:0]   ins;
  logic          ins_valid, fetch_err;
  logic          ld_start = 1'b0, ld_end = 1'b0, ld_valid = 1'b0;
  logic [7:0]    ld_byte = '0;
  logic          ld_ready, ld_busy;
  logic [IW:0]   ld_words;

  int n_tests = 0;
  int n_fail  = 0;

  imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .PC_i(PC_i), .fetch_en(fetch_en),
    .ins(ins), .ins_valid(ins_valid), .fetch_err(fetch_err),
    .ld_start(ld_start), .ld_end(ld_end), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_words(ld_words)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1; step(); ld_start = 1'b0;
  endtask

  task automatic pulse_end();
    ld_end = 1'b1; step(); ld_end = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    int n = 0;
    ld_valid = 1'b1;
    ld_byte  = b;
    while (!ld_ready && n < 8) begin
      step();
      n++;
    end
    if (n >= 8) chk("ld_ready_timeout", 32'(ld_ready), 32'd1);
    ld_end = e;
    step();
    ld_valid = 1'b0;
    ld_end   = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0);
  endtask

  task automatic fetch(input logic [31:0] pc);
    PC_i = pc; fetch_en = 1'b1; step(); fetch_en = 1'b0;
  endtask

  initial begin
    logic [31:0] wv;
    step(); step();
    rst = 1'b0;
    chk("rst_ins",       ins, 32'h13);
    chk("rst_ins_valid", 32'(ins_valid), 0);
    chk("rst_fetch_err", 32'(fetch_err), 0);
    chk("rst_ld_busy",   32'(ld_busy), 0);
    chk("rst_ld_ready",  32'(ld_ready), 0);
    chk("rst_ld_words",  32'(ld_words), 0);

    fetch(32'h0);
    chk("f0_empty_ins",   ins, 32'h13);
    chk("f0_empty_valid", 32'(ins_valid), 1);
    chk("f0_empty_err",   32'(fetch_err), 0);
    step();
    chk("idle_valid_drop", 32'(ins_valid), 0);
    chk("idle_ins_hold",   ins, 32'h13);

    // two-word program, end arrives during the final WRITE
    pulse_start();
    chk("ld_busy_load",  32'(ld_busy), 1);
    chk("ld_ready_load", 32'(ld_ready), 1);
    send_word(32'h0010_0093);
    send_word(32'h0020_0113);
    pulse_end();
    chk("prog_busy",  32'(ld_busy), 0);
    chk("prog_words", 32'(ld_words), 2);
    fetch(32'h0);
    chk("prog_w0", ins, 32'h0010_0093);
    chk("prog_w0_valid", 32'(ins_valid), 1);
    fetch(32'h4);
    chk("prog_w1", ins, 32'h0020_0113);
    fetch(32'h8);
    chk("unloaded_ins", ins, 32'h13);
    chk("unloaded_err", 32'(fetch_err), 0);
    fetch(32'h2);
    chk("misalign_ins", ins, 32'h13);
    chk("misalign_err", 32'(fetch_err), 1);
    fetch(32'(4 * DEPTH));
    chk("oor_ins", ins, 32'h13);
    chk("oor_err", 32'(fetch_err), 1);

    // six bytes then end: second word partial and discarded
    pulse_start();
    send_word(32'h4433_2211);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    pulse_end();
    chk("part_busy",  32'(ld_busy), 0);
    chk("part_words", 32'(ld_words), 1);
    fetch(32'h0);
    chk("part_w0", ins, 32'h4433_2211);
    fetch(32'h4);
    chk("part_w1_masked", ins, 32'h13);

    // end coincident with the 4th byte commits that word
    pulse_start();
    send_byte(8'haa, 1'b0);
    send_byte(8'hbb, 1'b0);
    send_byte(8'hcc, 1'b0);
    send_byte(8'hdd, 1'b1);
    chk("end4_busy_write", 32'(ld_busy), 1);
    step();
    chk("end4_busy", 32'(ld_busy), 0);
    chk("end4_words", 32'(ld_words), 1);
    fetch(32'h0);
    chk("end4_w0", ins, 32'hddcc_bbaa);

    // restart in LOAD drops the partial word
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    pulse_start();
    chk("restart_words", 32'(ld_words), 0);
    send_word(32'hcafe_f00d);
    pulse_end();
    chk("restart_words_end", 32'(ld_words), 1);
    fetch(32'h0);
    chk("restart_w0", ins, 32'hcafe_f00d);

    // fill to capacity
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      wv = 32'ha500_0000 | 32'(i);
      send_word(wv);
    end
    step();
    chk("full_ready", 32'(ld_ready), 0);
    chk("full_busy",  32'(ld_busy), 1);
    chk("full_words", 32'(ld_words), DEPTH);
    ld_valid = 1'b1; ld_byte = 8'h77;
    step(); step(); step();
    ld_valid = 1'b0;
    chk("full_words_extra", 32'(ld_words), DEPTH);
    pulse_end();
    chk("full_idle", 32'(ld_busy), 0);
    fetch(32'(4 * (DEPTH - 1)));
    chk("full_last", ins, 32'ha500_0000 | 32'(DEPTH - 1));
    chk("full_last_err", 32'(fetch_err), 0);
    fetch(32'h0);
    chk("full_first", ins, 32'ha500_0000);

    // reset mid-load
    pulse_start();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_busy",  32'(ld_busy), 0);
    chk("midrst_words", 32'(ld_words), 0);
    fetch(32'h0);
    chk("midrst_ins",   ins, 32'h13);
    chk("midrst_valid", 32'(ins_valid), 1);

    // fetch while loading is refused
    pulse_start();
    fetch(32'h0);
    chk("loadfetch_valid", 32'(ins_valid), 0);
    chk("loadfetch_ins",   ins, 32'h13);
    pulse_end();
    chk("loadfetch_idle", 32'(ld_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
